// File: rtl/axi_lite_cmd_master.sv
// Command-port to AXI4-Lite master bridge. Accepts one read or write command,
// runs exactly one AXI4-Lite transaction, then holds a single response beat
// until the consumer takes it. Only one transaction is in flight at a time.
module axi_lite_cmd_master #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   // command port
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   // response port
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_write,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_resp,
   // AXI write address
   output logic [ADDR_WIDTH-1:0] AWADDR,
   output logic                  AWVALID,
   input  logic                  AWREADY,
   // AXI write data
   output logic [DATA_WIDTH-1:0] WDATA,
   output logic                  WVALID,
   input  logic                  WREADY,
   // AXI write response
   input  logic [1:0]            BRESP,
   input  logic                  BVALID,
   output logic                  BREADY,
   // AXI read address
   output logic [ADDR_WIDTH-1:0] ARADDR,
   output logic                  ARVALID,
   input  logic                  ARREADY,
   // AXI read data
   input  logic [DATA_WIDTH-1:0] RDATA,
   input  logic [1:0]            RRESP,
   input  logic                  RVALID,
   output logic                  RREADY
);

   // state      | meaning
   // S_IDLE     | cmd_ready high, waiting for a command
   // S_WRITE    | AW and W channels driven, each retired independently
   // S_WRESP    | BREADY high, waiting for the write response
   // S_READ     | ARVALID high, waiting for ARREADY
   // S_RDATA_ST | RREADY high, waiting for read data
   // S_RSP      | response beat held until rsp_ready
   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_WRESP,
      S_READ,
      S_RDATA_ST,
      S_RSP
   } state_t;

   state_t state;
   logic   aw_acc;
   logic   w_acc;
   logic   aw_hs;
   logic   w_hs;

   // Handshakes on the two write request channels in the current cycle.
   always_comb begin
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
   end

   // Transaction sequencer; every output is a register so nothing combinational
   // reaches the slave or the command/response ports.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state     <= S_IDLE;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_rdata <= '0;
         rsp_resp  <= 2'b00;
         AWADDR    <= '0;
         AWVALID   <= 1'b0;
         WDATA     <= '0;
         WVALID    <= 1'b0;
         BREADY    <= 1'b0;
         ARADDR    <= '0;
         ARVALID   <= 1'b0;
         RREADY    <= 1'b0;
         aw_acc    <= 1'b0;
         w_acc     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_ready && cmd_valid) begin
                  cmd_ready <= 1'b0;
                  if (cmd_write) begin
                     AWADDR  <= cmd_addr;
                     WDATA   <= cmd_wdata;
                     AWVALID <= 1'b1;
                     WVALID  <= 1'b1;
                     aw_acc  <= 1'b0;
                     w_acc   <= 1'b0;
                     state   <= S_WRITE;
                  end else begin
                     ARADDR  <= cmd_addr;
                     ARVALID <= 1'b1;
                     state   <= S_READ;
                  end
               end else begin
                  // first cycle out of reset lands here with cmd_ready low
                  cmd_ready <= 1'b1;
               end
            end
            S_WRITE: begin
               if (aw_hs) begin
                  AWVALID <= 1'b0;
                  aw_acc  <= 1'b1;
               end
               if (w_hs) begin
                  WVALID <= 1'b0;
                  w_acc  <= 1'b1;
               end
               if ((aw_acc || aw_hs) && (w_acc || w_hs)) begin
                  BREADY <= 1'b1;
                  state  <= S_WRESP;
               end
            end
            S_WRESP: begin
               if (BVALID) begin
                  BREADY    <= 1'b0;
                  rsp_resp  <= BRESP;
                  rsp_write <= 1'b1;
                  rsp_rdata <= '0;
                  rsp_valid <= 1'b1;
                  state     <= S_RSP;
               end
            end
            S_READ: begin
               if (ARREADY) begin
                  ARVALID <= 1'b0;
                  RREADY  <= 1'b1;
                  state   <= S_RDATA_ST;
               end
            end
            S_RDATA_ST: begin
               if (RVALID) begin
                  RREADY    <= 1'b0;
                  rsp_resp  <= RRESP;
                  rsp_write <= 1'b0;
                  rsp_rdata <= RDATA;
                  rsp_valid <= 1'b1;
                  state     <= S_RSP;
               end
            end
            S_RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master against a small register-file slave model.
// The slave answers each VALID with a registered READY pulse, raises BVALID
// one cycle after both write channels are retired, and returns RVALID on the
// edge of the AR handshake. With that slave a write takes 5 edges from accept
// to rsp_valid and a read 4 (accept edge counted as 1).
module tb_axi_lite_cmd_master;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [3:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [3:0]  AWADDR, ARADDR;
   logic        AWVALID, AWREADY, WVALID, WREADY;
   logic [31:0] WDATA, RDATA;
   logic [1:0]  BRESP, RRESP;
   logic        BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;

   int passed = 0;
   int total  = 0;

   // slave knobs
   int aw_stall = 0;
   bit rerr     = 1'b0;

   axi_lite_cmd_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
   );

   always #5 ACLK = ~ACLK;

   // ---------------- slave model ----------------
   logic [31:0] mem [4];
   logic        aw_got, w_got;
   logic [3:0]  awaddr_l;
   logic [31:0] wdata_l;
   int          aw_cnt;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         AWREADY  <= 1'b0;
         WREADY   <= 1'b0;
         BVALID   <= 1'b0;
         BRESP    <= 2'b00;
         ARREADY  <= 1'b0;
         RVALID   <= 1'b0;
         RDATA    <= '0;
         RRESP    <= 2'b00;
         aw_got   <= 1'b0;
         w_got    <= 1'b0;
         awaddr_l <= '0;
         wdata_l  <= '0;
         aw_cnt   <= 0;
      end else begin
         if (AWVALID && AWREADY) begin
            aw_got   <= 1'b1;
            awaddr_l <= AWADDR;
            AWREADY  <= 1'b0;
            aw_cnt   <= 0;
         end else if (AWVALID && !aw_got) begin
            if (aw_cnt >= aw_stall) AWREADY <= 1'b1;
            else                    aw_cnt  <= aw_cnt + 1;
         end
         if (WVALID && WREADY) begin
            w_got   <= 1'b1;
            wdata_l <= WDATA;
            WREADY  <= 1'b0;
         end else if (WVALID && !w_got) begin
            WREADY <= 1'b1;
         end
         if (aw_got && w_got && !BVALID) begin
            BVALID <= 1'b1;
            BRESP  <= 2'b00;
            mem[awaddr_l[3:2]] <= wdata_l;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
         end else if (BVALID && BREADY) begin
            BVALID <= 1'b0;
         end
         if (RVALID && RREADY) RVALID <= 1'b0;
         if (ARVALID && ARREADY) begin
            ARREADY <= 1'b0;
            RVALID  <= 1'b1;
            RDATA   <= rerr ? 32'hDEADBEEF : mem[ARADDR[3:2]];
            RRESP   <= rerr ? 2'b10 : 2'b00;
         end else if (ARVALID) begin
            ARREADY <= 1'b1;
         end
      end
   end

   // count of write-response handshakes seen on the bus
   int b_hs = 0;
   always @(posedge ACLK) if (BVALID && BREADY) b_hs <= b_hs + 1;

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Issues one command, waits for the response, optionally consumes it.
   task automatic do_cmd(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                         input bit consume, output int lat, output bit busy_bad,
                         output logic [31:0] rd, output logic [1:0] rp, output logic rw);
      int n;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wd;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 40) begin
         @(posedge ACLK); #1;
         n++;
      end
      if (!cmd_ready) chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
      @(posedge ACLK); #1;
      cmd_valid = 1'b0;
      lat      = 1;
      busy_bad = 1'b0;
      while (!rsp_valid && lat < 40) begin
         if (cmd_ready) busy_bad = 1'b1;
         @(posedge ACLK); #1;
         lat++;
      end
      if (cmd_ready) busy_bad = 1'b1;
      rd = rsp_rdata;
      rp = rsp_resp;
      rw = rsp_write;
      if (consume) begin
         rsp_ready = 1'b1;
         @(posedge ACLK); #1;
         rsp_ready = 1'b0;
      end
   endtask

   typedef struct {
      logic        wr;
      logic [3:0]  addr;
      logic [31:0] wdata;
      bit          err;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      int          exp_lat;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int          lat;
      bit          bb;
      logic [31:0] rd;
      logic [1:0]  rp;
      logic        rw;
      int          b_base;

      vecs[0] = '{1'b1, 4'h4, 32'hA5A50001, 1'b0, 32'h0,        2'b00, 5};
      vecs[1] = '{1'b0, 4'h4, 32'h0,        1'b0, 32'hA5A50001, 2'b00, 4};
      vecs[2] = '{1'b1, 4'h0, 32'h11,       1'b0, 32'h0,        2'b00, 5};
      vecs[3] = '{1'b1, 4'h8, 32'h22,       1'b0, 32'h0,        2'b00, 5};
      vecs[4] = '{1'b1, 4'hC, 32'h33,       1'b0, 32'h0,        2'b00, 5};
      vecs[5] = '{1'b0, 4'hC, 32'h0,        1'b0, 32'h33,       2'b00, 4};
      vecs[6] = '{1'b0, 4'h8, 32'h0,        1'b0, 32'h22,       2'b00, 4};
      vecs[7] = '{1'b0, 4'h0, 32'h0,        1'b0, 32'h11,       2'b00, 4};
      vecs[8] = '{1'b0, 4'h4, 32'h0,        1'b1, 32'hDEADBEEF, 2'b10, 4};

      ARESETN   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      rsp_ready = 1'b0;

      // reset state
      repeat (2) @(posedge ACLK);
      #1;
      chk("reset_valids", 64'({cmd_ready, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY}), 64'd0);
      chk("reset_data", 64'({AWADDR, ARADDR, WDATA, rsp_rdata, rsp_resp, rsp_write}), 64'd0);
      @(negedge ACLK);
      ARESETN = 1'b1;
      @(posedge ACLK); #1;
      chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);

      // table-driven transactions
      for (int i = 0; i < 9; i++) begin
         rerr = vecs[i].err;
         do_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b1, lat, bb, rd, rp, rw);
         chk($sformatf("v%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
         chk($sformatf("v%0d_resp", i), 64'(rp), 64'(vecs[i].exp_resp));
         chk($sformatf("v%0d_write", i), 64'(rw), 64'(vecs[i].wr));
         chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
         chk($sformatf("v%0d_busy_cmd_ready", i), 64'(bb), 64'd0);
         chk($sformatf("v%0d_rsp_dropped", i), 64'(rsp_valid), 64'd0);
      end
      rerr = 1'b0;

      // response back-pressure: hold rsp_ready low for 10 cycles
      do_cmd(1'b0, 4'h8, 32'h0, 1'b0, lat, bb, rd, rp, rw);
      chk("hold_first_rdata", 64'(rd), 64'h22);
      for (int k = 0; k < 10; k++) begin
         @(posedge ACLK); #1;
         chk($sformatf("hold_c%0d", k),
             64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata, cmd_ready, ARVALID}),
             64'({1'b1, 1'b0, 2'b00, 32'h22, 1'b0, 1'b0}));
      end
      rsp_ready = 1'b1;
      @(posedge ACLK); #1;
      rsp_ready = 1'b0;
      chk("hold_release", 64'({rsp_valid, cmd_ready}), 64'b01);

      // AWREADY stalled 3 cycles behind WREADY
      aw_stall  = 3;
      b_base    = b_hs;
      cmd_write = 1'b1;
      cmd_addr  = 4'h4;
      cmd_wdata = 32'h55;
      cmd_valid = 1'b1;
      @(posedge ACLK); #1;
      cmd_valid = 1'b0;
      chk("stall_k0", 64'({AWVALID, WVALID}), 64'b11);
      @(posedge ACLK); #1;
      @(posedge ACLK); #1;
      chk("stall_k2_w_dropped", 64'({AWVALID, WVALID}), 64'b10);
      @(posedge ACLK); #1;
      @(posedge ACLK); #1;
      chk("stall_k4_aw_held", 64'({AWVALID, WVALID, BREADY}), 64'b100);
      @(posedge ACLK); #1;
      chk("stall_k5_aw_done", 64'({AWVALID, BREADY}), 64'b01);
      @(posedge ACLK); #1;
      chk("stall_k6_no_rsp", 64'(rsp_valid), 64'd0);
      @(posedge ACLK); #1;
      chk("stall_k7_rsp", 64'({rsp_valid, rsp_write, rsp_resp, BREADY}), 64'b11000);
      rsp_ready = 1'b1;
      @(posedge ACLK); #1;
      rsp_ready = 1'b0;
      chk("stall_single_b", 64'(b_hs - b_base), 64'd1);
      aw_stall = 0;
      do_cmd(1'b0, 4'h4, 32'h0, 1'b1, lat, bb, rd, rp, rw);
      chk("stall_readback", 64'(rd), 64'h55);

      // reset while waiting for the write response
      cmd_write = 1'b1;
      cmd_addr  = 4'hC;
      cmd_wdata = 32'h77;
      cmd_valid = 1'b1;
      @(posedge ACLK); #1;
      cmd_valid = 1'b0;
      @(posedge ACLK); #1;
      @(posedge ACLK); #1;
      chk("rst_in_wresp", 64'({BREADY, rsp_valid}), 64'b10);
      ARESETN = 1'b0;
      #1;
      chk("rst_async_outputs",
          64'({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, cmd_ready}), 64'd0);
      @(negedge ACLK);
      ARESETN = 1'b1;
      @(posedge ACLK); #1;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      do_cmd(1'b0, 4'h0, 32'h0, 1'b1, lat, bb, rd, rp, rw);
      chk("rst_read_data", 64'({rd, rp, rw}), 64'({32'h11, 2'b00, 1'b0}));
      chk("rst_read_latency", 64'(lat), 64'd4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
